// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: register ids, write enables and stage events in,
// stall/flush/forward controls and divider status out. master = pipeline, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0] rs_D, rt_D, rs_E, rt_E;
    logic [4:0] write_reg_E, write_reg_M, write_reg_W;
    logic       reg_wr_E, reg_wr_M, reg_wr_W;
    logic       mem_to_reg_E, mispredict_E, div_start_E;
    logic       mem_req_M, dmem_ack, except_M;
    logic       stall_F, stall_D, stall_E, stall_M, stall_W;
    logic       flush_D, flush_E, flush_M, flush_W;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic       div_busy, div_done;

    modport master (
        output rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W,
               reg_wr_E, reg_wr_M, reg_wr_W, mem_to_reg_E, mispredict_E, div_start_E,
               mem_req_M, dmem_ack, except_M,
        input  stall_F, stall_D, stall_E, stall_M, stall_W,
               flush_D, flush_E, flush_M, flush_W, fwd_a_E, fwd_b_E, div_busy, div_done
    );

    modport slave (
        input  rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W,
               reg_wr_E, reg_wr_M, reg_wr_W, mem_to_reg_E, mispredict_E, div_start_E,
               mem_req_M, dmem_ack, except_M,
        output stall_F, stall_D, stall_E, stall_M, stall_W,
               flush_D, flush_E, flush_M, flush_W, fwd_a_E, fwd_b_E, div_busy, div_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: prioritised stall/flush, E-stage forwarding, multi-cycle divide FSM.
// Define HAZARD_FWD_EN to enable M/W forwarding; otherwise RAW hazards in D stall instead.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 34
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    div_state_t state, state_nxt;
    logic [5:0] count, count_nxt;

    logic       mem_stall, div_stall, dep_stall, load_use;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic hit(input logic [4:0] dst, input logic we, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    assign mem_stall = hz.mem_req_M && !hz.dmem_ack;
    assign div_stall = (state == S_IDLE && hz.div_start_E) || (state == S_BUSY);
    assign load_use  = hz.mem_to_reg_E &&
                       (hit(hz.write_reg_E, hz.reg_wr_E, hz.rs_D) ||
                        hit(hz.write_reg_E, hz.reg_wr_E, hz.rt_D));

`ifdef HAZARD_FWD_EN
    assign dep_stall = load_use;
    // M is the younger producer, so it wins over W.
    assign fwd_a = hit(hz.write_reg_M, hz.reg_wr_M, hz.rs_E) ? 2'b10 :
                   hit(hz.write_reg_W, hz.reg_wr_W, hz.rs_E) ? 2'b01 : 2'b00;
    assign fwd_b = hit(hz.write_reg_M, hz.reg_wr_M, hz.rt_E) ? 2'b10 :
                   hit(hz.write_reg_W, hz.reg_wr_W, hz.rt_E) ? 2'b01 : 2'b00;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.rs_E, hz.rt_E, hz.write_reg_W, hz.reg_wr_W};
    // No bypass network: any producer still in E or M holds the consumer in D.
    assign dep_stall = load_use ||
                       hit(hz.write_reg_E, hz.reg_wr_E, hz.rs_D) ||
                       hit(hz.write_reg_E, hz.reg_wr_E, hz.rt_D) ||
                       hit(hz.write_reg_M, hz.reg_wr_M, hz.rs_D) ||
                       hit(hz.write_reg_M, hz.reg_wr_M, hz.rt_D);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // BUSY holds count cycles; the start cycle in IDLE supplies the extra stall cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            S_IDLE: begin
                if (hz.div_start_E && !hz.except_M && !mem_stall) begin
                    if (DIV_LOAD == 6'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_BUSY;
                        count_nxt = DIV_LOAD;
                    end
                end
            end
            S_BUSY: begin
                if (hz.except_M) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end else if (!mem_stall) begin
                    count_nxt = count - 6'd1;
                    if (count == 6'd1) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        hz.stall_F  = 1'b0;
        hz.stall_D  = 1'b0;
        hz.stall_E  = 1'b0;
        hz.stall_M  = 1'b0;
        hz.stall_W  = 1'b0;
        hz.flush_D  = 1'b0;
        hz.flush_E  = 1'b0;
        hz.flush_M  = 1'b0;
        hz.flush_W  = 1'b0;
        hz.fwd_a_E  = 2'b00;
        hz.fwd_b_E  = 2'b00;
        hz.div_busy = 1'b0;
        hz.div_done = 1'b0;
        if (!rst) begin
            hz.fwd_a_E  = fwd_a;
            hz.fwd_b_E  = fwd_b;
            hz.div_busy = (state == S_BUSY);
            hz.div_done = (state == S_DONE);
            if (hz.except_M) begin
                hz.flush_D = 1'b1;
                hz.flush_E = 1'b1;
                hz.flush_M = 1'b1;
                hz.flush_W = 1'b1;
            end else if (mem_stall) begin
                hz.stall_F = 1'b1;
                hz.stall_D = 1'b1;
                hz.stall_E = 1'b1;
                hz.stall_M = 1'b1;
                hz.flush_W = 1'b1;
            end else if (div_stall) begin
                hz.stall_F = 1'b1;
                hz.stall_D = 1'b1;
                hz.stall_E = 1'b1;
                hz.flush_M = 1'b1;
            end else if (dep_stall) begin
                hz.stall_F = 1'b1;
                hz.stall_D = 1'b1;
                hz.flush_E = 1'b1;
            end else if (hz.mispredict_E) begin
                // Only the wrong-path fetch is squashed; the delay slot in D proceeds.
                hz.flush_D = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; expectations adapt to the HAZARD_FWD_EN build.
module tb_hazard_ctrl;

    localparam int DC = 34;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    hazard_ctrl_if hz ();
    sb_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(.DIV_CYCLES(DC)) dut (.clk(clk), .rst(rst), .hz(hz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st = {stall_F, stall_D, stall_E, stall_M}, fl = {flush_D, flush_E, flush_M, flush_W}; stall_W always 0
    function automatic logic [14:0] ex(input logic [3:0] st, input logic [3:0] fl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic busy, input logic done);
        return {st, 1'b0, fl, fa, fb, busy, done};
    endfunction

    localparam logic [3:0] ST_MEM = 4'b1111, ST_DIV = 4'b1110, ST_LU = 4'b1100;
    localparam logic [3:0] FL_MEM = 4'b0001, FL_DIV = 4'b0010, FL_LU = 4'b0100;
    localparam logic [3:0] FL_MIS = 4'b1000, FL_EXC = 4'b1111;

    task automatic clear_inputs();
        hz.rs_D = 5'd0; hz.rt_D = 5'd0; hz.rs_E = 5'd0; hz.rt_E = 5'd0;
        hz.write_reg_E = 5'd0; hz.write_reg_M = 5'd0; hz.write_reg_W = 5'd0;
        hz.reg_wr_E = 1'b0; hz.reg_wr_M = 1'b0; hz.reg_wr_W = 1'b0;
        hz.mem_to_reg_E = 1'b0; hz.mispredict_E = 1'b0; hz.div_start_E = 1'b0;
        hz.mem_req_M = 1'b0; hz.dmem_ack = 1'b0; hz.except_M = 1'b0;
    endtask

    task automatic check_out();
        sb_t s;
        logic [14:0] o;
        s = sb_q.pop_front();
        o = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.stall_W,
             hz.flush_D, hz.flush_E, hz.flush_M, hz.flush_W,
             hz.fwd_a_E, hz.fwd_b_E, hz.div_busy, hz.div_done};
        n_cmp++;
        assert (o === s.exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", s.tag, o, s.exp);
        end
    endtask

    // Push expectation for the inputs just driven, compare mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [14:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sb_q.push_back(s);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [1:0] f10, f01;
        f10 = FWD ? 2'b10 : 2'b00;
        f01 = FWD ? 2'b01 : 2'b00;

        // reset dominates every active input
        clear_inputs();
        rst = 1'b1;
        hz.except_M = 1'b1; hz.mem_req_M = 1'b1; hz.div_start_E = 1'b1;
        hz.rs_E = 5'd5; hz.write_reg_M = 5'd5; hz.reg_wr_M = 1'b1;
        cyc("rst0", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        cyc("rst1", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        rst = 1'b0;
        clear_inputs();
        cyc("idle", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));

        // forwarding
        hz.rs_E = 5'd5; hz.rt_E = 5'd5;
        hz.write_reg_M = 5'd5; hz.reg_wr_M = 1'b1; hz.write_reg_W = 5'd5; hz.reg_wr_W = 1'b1;
        cyc("fwd_m_pri", ex(4'b0, 4'b0, f10, f10, 1'b0, 1'b0));
        hz.reg_wr_M = 1'b0;
        cyc("fwd_w", ex(4'b0, 4'b0, f01, f01, 1'b0, 1'b0));
        hz.rs_E = 5'd0;
        cyc("fwd_rs0", ex(4'b0, 4'b0, 2'b00, f01, 1'b0, 1'b0));
        hz.rt_E = 5'd0; hz.write_reg_M = 5'd0; hz.write_reg_W = 5'd0; hz.reg_wr_M = 1'b1;
        cyc("fwd_r0", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.rs_E = 5'd7; hz.rt_E = 5'd5; hz.write_reg_M = 5'd5; hz.write_reg_W = 5'd7;
        cyc("fwd_mix", ex(4'b0, 4'b0, f01, f10, 1'b0, 1'b0));
        clear_inputs();

        // load-use and RAW dependences in D
        hz.reg_wr_E = 1'b1; hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd8; hz.rt_D = 5'd8;
        cyc("lu", ex(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.reg_wr_E = 1'b0; hz.mem_to_reg_E = 1'b0;
        cyc("lu_once", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.reg_wr_E = 1'b1; hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd0; hz.rt_D = 5'd0;
        cyc("lu_r0", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.mem_to_reg_E = 1'b0; hz.write_reg_E = 5'd8; hz.rs_D = 5'd8;
        cyc("raw_e", FWD ? ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0)
                         : ex(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();
        hz.reg_wr_M = 1'b1; hz.write_reg_M = 5'd3; hz.rs_D = 5'd3;
        cyc("raw_m", FWD ? ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0)
                         : ex(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();

        // mispredict, memory stall, exception priority
        hz.mispredict_E = 1'b1;
        cyc("mis", ex(4'b0, FL_MIS, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.reg_wr_E = 1'b1; hz.mem_to_reg_E = 1'b1; hz.write_reg_E = 5'd9; hz.rs_D = 5'd9;
        cyc("lu_over_mis", ex(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.mem_req_M = 1'b1;
        cyc("mem_over_lu", ex(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.dmem_ack = 1'b1;
        cyc("mem_ack", ex(ST_LU, FL_LU, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();
        hz.mem_req_M = 1'b1; hz.except_M = 1'b1; hz.mispredict_E = 1'b1;
        cyc("exc_over_mem", ex(4'b0, FL_EXC, 2'b00, 2'b00, 1'b0, 1'b0));
        clear_inputs();

        // plain divide: 33 stall cycles, 32 busy, one done
        hz.div_start_E = 1'b1;
        cyc("div_start", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.div_start_E = 1'b0;
        for (int i = 0; i < DC - 2; i++)
            cyc("div_busy", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b1, 1'b0));
        cyc("div_done", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b1));
        cyc("div_idle", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));

        // divide held off by memory stall, then extended by one mid-busy
        hz.div_start_E = 1'b1; hz.mem_req_M = 1'b1;
        cyc("divm_hold", ex(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.mem_req_M = 1'b0;
        cyc("divm_start", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < DC + 1; i++) begin
            hz.mem_req_M = (i >= 5 && i <= 7);
            if (i >= 5 && i <= 7)
                cyc("divm_mem", ex(ST_MEM, FL_MEM, 2'b00, 2'b00, 1'b1, 1'b0));
            else
                cyc("divm_busy", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b1, 1'b0));
        end
        hz.mem_req_M = 1'b0;
        cyc("divm_done", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b1));
        hz.div_start_E = 1'b0;
        cyc("divm_norestart", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));

        // exception at busy cycle 10 aborts
        hz.div_start_E = 1'b1;
        cyc("dive_start", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.div_start_E = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc("dive_busy", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b1, 1'b0));
        hz.except_M = 1'b1;
        cyc("dive_exc", ex(4'b0, FL_EXC, 2'b00, 2'b00, 1'b1, 1'b0));
        hz.except_M = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("dive_nodone", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));

        // reset mid-divide aborts with no done pulse
        hz.div_start_E = 1'b1;
        cyc("divr_start", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b0, 1'b0));
        hz.div_start_E = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc("divr_busy", ex(ST_DIV, FL_DIV, 2'b00, 2'b00, 1'b1, 1'b0));
        rst = 1'b1;
        cyc("divr_rst", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("divr_nodone", ex(4'b0, 4'b0, 2'b00, 2'b00, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
